multi_cs_pipe: RTL

Pipelined, parametrised successor to the 4-bit combinational carry-save multiplier. It multiplies two WIDTH-bit operands through a carry-save partial-product array split into registered stages, followed by a registered carry-propagate adder. It accepts one operation per cycle under a valid/ready handshake with full back-pressure, and supports signed or unsigned operation per transaction. It sits between operand producers and arithmetic consumers that need throughput rather than single-cycle latency.

---
 rtl/multi_cs_pipe.sv | 88 ++++++++
 1 files changed

// File: rtl/multi_cs_pipe.sv
// multi_cs_pipe: pipelined carry-save multiplier, signed/unsigned per transaction, valid/ready with full back-pressure
module multi_cs_pipe #(
  parameter int WIDTH          = 4,
  parameter int ROWS_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*WIDTH:0] out_product,
  output logic             busy
);
  localparam int W = WIDTH;
  localparam int R = ROWS_PER_STAGE;
  localparam int S = (W + R - 1) / R;
  localparam int P = 2 * W;
  logic         w_stall;
  logic [S-1:0] w_vs;
  logic [P-1:0] w_sum;
  logic         r_ov;
  logic [P:0]   r_p;
  function automatic logic [P-1:0] row(input logic [W-1:0] a, input logic b, input logic sg, input int i);
    logic [W-1:0] t;
    t = a & {W{b}};
    if (sg) t = t ^ ((i == W - 1) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}});
    return P'(t) << i;
  endfunction
  function automatic logic [2*P-1:0] csa(input logic [P-1:0] x, input logic [P-1:0] y, input logic [P-1:0] z);
    return {(x & y | x & z | y & z) << 1, x ^ y ^ z};
  endfunction
  assign w_stall = r_ov && !out_ready;
  assign in_ready = !w_stall;
  for (genvar g = 0; g < S; g++) begin : g_st
    localparam int LO = g * R;
    localparam int HI = (LO + R > W) ? W : LO + R;
    logic            w_v, w_sg;
    logic [W-1:0]    w_a;
    logic [W-LO-1:0] w_b;
    logic [P-1:0]    w_s, w_c, w_ns, w_nc;
    logic            r_v, r_sg;
    logic [P-1:0]    r_s, r_c;
    if (g == 0) begin : g_src
      assign w_v  = in_valid;
      assign w_sg = in_signed;
      assign w_a  = in_a;
      assign w_b  = in_b;
      assign w_s  = in_signed ? (P'(1) << W) | (P'(1) << (P - 1)) : '0;
      assign w_c  = '0;
    end else begin : g_src
      assign w_v  = g_st[g-1].r_v;
      assign w_sg = g_st[g-1].r_sg;
      assign w_a  = g_st[g-1].g_op.r_a;
      assign w_b  = g_st[g-1].g_op.r_b;
      assign w_s  = g_st[g-1].r_s;
      assign w_c  = g_st[g-1].r_c;
    end
    // fold this stage's partial-product rows into the running sum/carry pair
    always_comb begin
      {w_nc, w_ns} = {w_c, w_s};
      for (int i = LO; i < HI; i++) {w_nc, w_ns} = csa(w_ns, w_nc, row(w_a, w_b[i-LO], w_sg, i));
    end
    // advance with the pipeline unless stalled; only the valid bit needs reset
    always_ff @(posedge clk)
      if (rst) r_v <= 1'b0;
      else if (!w_stall) {r_v, r_sg, r_s, r_c} <= {w_v, w_sg, w_ns, w_nc};
    if (g < S - 1) begin : g_op
      logic [W-1:0]    r_a;
      logic [W-HI-1:0] r_b;
      // forward the multiplicand and only the multiplier bits later stages consume
      always_ff @(posedge clk)
        if (!w_stall) {r_a, r_b} <= {w_a, w_b[W-LO-1:HI-LO]};
    end
    assign w_vs[g] = r_v;
  end
  assign w_sum = g_st[S-1].r_s + g_st[S-1].r_c;
  // carry-propagate stage; the extra top bit is the sign extension in signed mode
  always_ff @(posedge clk)
    if (rst) {r_ov, r_p} <= '0;
    else if (!w_stall) {r_ov, r_p} <= {g_st[S-1].r_v, g_st[S-1].r_sg & w_sum[P-1], w_sum};
  assign out_valid   = r_ov;
  assign out_product = r_ov ? r_p : '0;
  assign busy        = |w_vs | r_ov;
endmodule
